conf_int_mul_noff_arch_agnos_w_wrapper: RTL and testbench
=========================================================

CONF_INT_MUL_NOFF_ARCH_AGNOS_W_WRAPPER -- requirements
Module: conf_int_mul_noff_arch_agnos_w_wrapper

Interface
REQ-001 SHALL have parameter OP_BITWIDTH, default 28: number of significant operand MSBs retained in approximate mode.
REQ-002 SHALL have parameter DATA_PATH_BITWIDTH, default 32: width of a, b and d.
REQ-003 SHALL have port clk, input, 1: single clock, all registers update on its rising edge.
REQ-004 SHALL have port rapx, input, 1: reset, asynchronous, active-high, clears every register.
REQ-005 SHALL have port racc, input, 1: accuracy-mode select, 1 = accurate product, 0 = approximate product.
REQ-006 SHALL have port a, input, DATA_PATH_BITWIDTH: signed two's-complement multiplicand.
REQ-007 SHALL have port b, input, DATA_PATH_BITWIDTH: signed two's-complement multiplier.
REQ-008 SHALL have port d, output, DATA_PATH_BITWIDTH: registered signed product.

Function
REQ-009 SHALL register a, b and racc together on each rising clk edge (input stage).
REQ-010 SHALL compute the product combinationally from the input-stage registers and register it into d on the next rising edge; latency from the a/b capture edge to d valid is 2 edges.
REQ-011 SHALL accept a new operand pair every cycle; no handshake, no stall, no bubbles.
REQ-012 Accurate mode (registered racc=1): d = low DATA_PATH_BITWIDTH bits of the full signed product a*b.
REQ-013 Approximate mode (registered racc=0): the low APX_BITS = DATA_PATH_BITWIDTH-OP_BITWIDTH bits of each operand are forced to 0 before multiplication; d = low DATA_PATH_BITWIDTH bits of the signed product of the masked operands.
REQ-014 Internal product SHALL be 2*DATA_PATH_BITWIDTH bits signed; overflow wraps silently by truncation, with no saturation and no flag.
REQ-015 When OP_BITWIDTH equals DATA_PATH_BITWIDTH, approximate mode SHALL equal accurate mode.
REQ-016 Mode applies per operand pair: racc changes take effect on the pair captured at the same edge.
REQ-017 Parameter legality: 1 <= OP_BITWIDTH <= DATA_PATH_BITWIDTH, checked at elaboration; an illegal value is an elaboration error.

Reset
REQ-018 While rapx=1, the input-stage registers, the registered mode bit and d SHALL be 0, asynchronously and irrespective of clk.
REQ-019 Registered mode after reset SHALL be 0 (approximate); since both operands are 0, d stays 0.
REQ-020 Reset asserted mid-operation SHALL discard all in-flight pairs; the first valid d after deassertion is 2 edges after the first capture.

Configuration
REQ-021 Macro CONF_MUL_APX_EN defined: approximate-mode masking logic present, and racc behaves per REQ-012/013.
REQ-022 Macro CONF_MUL_APX_EN undefined: masking logic and the racc register removed, racc ignored, and d is always the accurate product with latency unchanged.

Structure
REQ-023 Shared package conf_int_mul_pkg SHALL hold the default OP_BITWIDTH/DATA_PATH_BITWIDTH constants and the APX_BITS derivation function.
REQ-024 A sub-module conf_int_mul_core SHALL hold the purely combinational mask-and-multiply, with no flip-flops; the top holds only the registers.

Verification
REQ-025 racc=1, a=3, b=-5 -> d=-15 (0xFFFFFFF1) 2 edges after capture.
REQ-026 racc=1, a=-1, b=-1 -> d=1; a=0x00010000, b=0x00010000 -> d=0 (wraparound).
REQ-027 racc=0, OP_BITWIDTH=28, a=19, b=33 -> d=16*32=512 (0x200); same pair with racc=1 -> d=627.
REQ-028 500 back-to-back random pairs, racc=1, one per cycle -> each d equals the reference product of the pair captured 2 edges earlier, with no gaps.
REQ-029 rapx pulsed high between clk edges while d is nonzero -> d=0 immediately; after release, outputs are 0 until 2 edges after the first new capture.
REQ-030 Build without CONF_MUL_APX_EN, racc=0, a=19, b=33 -> d=627.

Source files
------------

// File: rtl/conf_int_mul_pkg.sv
// ----------------------------------------------------------------------------
// conf_int_mul_pkg
// Shared constants and helpers for the configurable-accuracy integer
// multiplier.
//   DEF_OP_BITWIDTH        : default count of operand MSBs kept in approximate mode
//   DEF_DATA_PATH_BITWIDTH : default operand / product width
//   apx_bits()             : number of operand LSBs zeroed in approximate mode
// ----------------------------------------------------------------------------
package conf_int_mul_pkg;

  localparam int unsigned DEF_OP_BITWIDTH        = 28;
  localparam int unsigned DEF_DATA_PATH_BITWIDTH = 32;

  // LSBs dropped in approximate mode; clamps to 0 so a misconfigured
  // OP_BITWIDTH never yields a negative shift before the elaboration check.
  function automatic int unsigned apx_bits(input int unsigned dp_w,
                                           input int unsigned op_w);
    if (op_w >= dp_w) begin
      return 32'd0;
    end
    return dp_w - op_w;
  endfunction

endpackage : conf_int_mul_pkg

// File: rtl/conf_int_mul_core.sv
// ----------------------------------------------------------------------------
// conf_int_mul_core
// Purely combinational mask-and-multiply. No state.
// Build option: CONF_MUL_APX_EN (defined = approximate-mode masking present,
// racc_i port exists; undefined = always the accurate product).
// Ports:
//   racc_i    : accuracy select, 1 = accurate, 0 = approximate (macro only)
//   a_i, b_i  : signed two's-complement operands
//   prod_c_o  : low DATA_PATH_BITWIDTH bits of the signed product (combinational)
// ----------------------------------------------------------------------------
module conf_int_mul_core
  import conf_int_mul_pkg::*;
#(
  parameter int unsigned OP_BITWIDTH        = DEF_OP_BITWIDTH,
  parameter int unsigned DATA_PATH_BITWIDTH = DEF_DATA_PATH_BITWIDTH
) (
`ifdef CONF_MUL_APX_EN
  input  logic                          racc_i,
`endif
  input  logic [DATA_PATH_BITWIDTH-1:0] a_i,
  input  logic [DATA_PATH_BITWIDTH-1:0] b_i,
  output logic [DATA_PATH_BITWIDTH-1:0] prod_c_o
);

  localparam int unsigned DW = DATA_PATH_BITWIDTH;
  localparam int unsigned PW = 2 * DW;

  logic [DW-1:0] a_m;
  logic [DW-1:0] b_m;

`ifdef CONF_MUL_APX_EN
  localparam int unsigned   APX_BITS  = apx_bits(DW, OP_BITWIDTH);
  // Ones in the retained MSB positions; all ones when APX_BITS is 0.
  localparam logic [DW-1:0] KEEP_MASK = {DW{1'b1}} << APX_BITS;

  // Approximate mode zeroes the operand LSBs; sign bit is always retained.
  always_comb begin
    a_m = a_i;
    b_m = b_i;
    if (!racc_i) begin
      a_m = a_i & KEEP_MASK;
      b_m = b_i & KEEP_MASK;
    end
  end
`else
  // Accurate-only build: operands pass straight through.
  assign a_m = a_i;
  assign b_m = b_i;
`endif

  // Full-width signed product; the result wraps by truncation to DW bits.
  logic signed [PW-1:0] a_ext;
  logic signed [PW-1:0] b_ext;
  logic signed [PW-1:0] prod;

  assign a_ext = $signed({{DW{a_m[DW-1]}}, a_m});
  assign b_ext = $signed({{DW{b_m[DW-1]}}, b_m});
  assign prod  = a_ext * b_ext;

  assign prod_c_o = prod[DW-1:0];

  // Upper half is intentionally discarded (silent wraparound).
  logic unused_prod_hi;
  assign unused_prod_hi = ^prod[PW-1:DW];

endmodule : conf_int_mul_core

// File: rtl/conf_int_mul_noff_arch_agnos_w_wrapper.sv
// ----------------------------------------------------------------------------
// conf_int_mul_noff_arch_agnos_w_wrapper
// Two-stage pipelined configurable-accuracy signed multiplier. The input
// stage captures a, b (and racc) each cycle; the product register d updates
// one edge later. No handshake, one pair accepted per cycle.
// Build option: CONF_MUL_APX_EN (defined = racc selects accurate/approximate;
// undefined = racc ignored, d is always the accurate product).
// Ports:
//   clk   : clock, rising edge
//   rapx  : asynchronous active-high reset, clears all registers
//   racc  : accuracy select, 1 = accurate, 0 = approximate
//   a, b  : signed two's-complement operands
//   d     : registered signed product (low DATA_PATH_BITWIDTH bits)
// ----------------------------------------------------------------------------
module conf_int_mul_noff_arch_agnos_w_wrapper
  import conf_int_mul_pkg::*;
#(
  parameter int unsigned OP_BITWIDTH        = DEF_OP_BITWIDTH,
  parameter int unsigned DATA_PATH_BITWIDTH = DEF_DATA_PATH_BITWIDTH
) (
  input  logic                          clk,
  input  logic                          rapx,
  input  logic                          racc,
  input  logic [DATA_PATH_BITWIDTH-1:0] a,
  input  logic [DATA_PATH_BITWIDTH-1:0] b,
  output logic [DATA_PATH_BITWIDTH-1:0] d
);

  localparam int unsigned DW = DATA_PATH_BITWIDTH;

  // Elaboration-time legality of the retained-bit count.
  generate
    if (OP_BITWIDTH < 1 || OP_BITWIDTH > DATA_PATH_BITWIDTH) begin : g_param_err
      $error("OP_BITWIDTH must lie in 1..DATA_PATH_BITWIDTH");
    end
  endgenerate

  logic [DW-1:0] a_q, a_d;
  logic [DW-1:0] b_q, b_d;
  logic [DW-1:0] d_q, d_d;
  logic [DW-1:0] prod_c;

`ifdef CONF_MUL_APX_EN
  logic racc_q, racc_d;
`else
  logic unused_racc;
  assign unused_racc = racc;
`endif

  // Next-state: input stage follows the ports, output stage follows the core.
  always_comb begin
    a_d = a;
    b_d = b;
    d_d = prod_c;
`ifdef CONF_MUL_APX_EN
    racc_d = racc;
`endif
  end

  // Pipeline registers; reset mode is approximate with zero operands.
  always_ff @(posedge clk or posedge rapx) begin
    if (rapx) begin
      a_q    <= '0;
      b_q    <= '0;
      d_q    <= '0;
`ifdef CONF_MUL_APX_EN
      racc_q <= 1'b0;
`endif
    end else begin
      a_q    <= a_d;
      b_q    <= b_d;
      d_q    <= d_d;
`ifdef CONF_MUL_APX_EN
      racc_q <= racc_d;
`endif
    end
  end

  conf_int_mul_core #(
    .OP_BITWIDTH        (OP_BITWIDTH),
    .DATA_PATH_BITWIDTH (DATA_PATH_BITWIDTH)
  ) u_core (
`ifdef CONF_MUL_APX_EN
    .racc_i   (racc_q),
`endif
    .a_i      (a_q),
    .b_i      (b_q),
    .prod_c_o (prod_c)
  );

  assign d = d_q;

endmodule : conf_int_mul_noff_arch_agnos_w_wrapper

// File: tb/tb_conf_int_mul_noff_arch_agnos_w_wrapper.sv
// ----------------------------------------------------------------------------
// Testbench for conf_int_mul_noff_arch_agnos_w_wrapper. A per-edge history of
// reference products (plain 64-bit arithmetic) predicts d on every cycle;
// directed pairs pin the reference with literal values.
// ----------------------------------------------------------------------------
module tb_conf_int_mul_noff_arch_agnos_w_wrapper;

  localparam int unsigned DW  = 32;
  localparam int unsigned OW  = 28;
  localparam int unsigned APX = DW - OW;
`ifdef CONF_MUL_APX_EN
  localparam bit APX_ON = 1'b1;
`else
  localparam bit APX_ON = 1'b0;
`endif

  logic          clk  = 1'b0;
  logic          rapx = 1'b1;
  logic          racc = 1'b0;
  logic [DW-1:0] a    = '0;
  logic [DW-1:0] b    = '0;
  logic [DW-1:0] d;

  int errors = 0;
  int checks = 0;

  conf_int_mul_noff_arch_agnos_w_wrapper #(
    .OP_BITWIDTH        (OW),
    .DATA_PATH_BITWIDTH (DW)
  ) u_dut (
    .clk  (clk),
    .rapx (rapx),
    .racc (racc),
    .a    (a),
    .b    (b),
    .d    (d)
  );

  always #5 clk = ~clk;

  // Reference: optionally zero the operand LSBs, multiply as signed 64-bit, truncate.
  function automatic logic [31:0] ref_mul(input logic [31:0] x, input logic [31:0] y,
                                          input logic acc);
    logic [31:0] keep;
    longint      sx, sy, p;
    keep = 32'hFFFF_FFFF << APX;
    if (APX_ON && !acc) begin
      x = x & keep;
      y = y & keep;
    end
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    p  = sx * sy;
    return p[31:0];
  endfunction

  // Per-edge history: product of the pair present at each rising edge, and
  // the last edge at or before which a reset discarded everything.
  logic [31:0] ref_at [0:4095];
  int edge_n   = 0;
  int rst_edge = 0;

  always @(posedge clk) begin
    edge_n = edge_n + 1;
    if (rapx) rst_edge = edge_n;
    ref_at[edge_n % 4096] = ref_mul(a, b, racc);
  end

  always @(posedge rapx) rst_edge = edge_n;

  // d after edge n reflects the pair sampled at edge n-1, if that edge followed reset.
  function automatic logic [31:0] expected_d();
    if (rapx) return 32'h0;
    if (edge_n - 1 > rst_edge) return ref_at[(edge_n - 1) % 4096];
    return 32'h0;
  endfunction

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] want);
    checks = checks + 1;
    if (got !== want) begin
      errors = errors + 1;
      $display("FAIL %s: d=%h expected=%h (t=%0t)", nm, got, want, $time);
    end
  endtask

  // Every-cycle compare against the model, away from the rising edge.
  always @(negedge clk) begin
    logic [31:0] want;
    want = expected_d();
    checks = checks + 1;
    if (d !== want) begin
      errors = errors + 1;
      $display("FAIL cycle edge=%0d: d=%h expected=%h", edge_n, d, want);
    end
  end

  // Drive one pair, then check d two edges after its capture.
  task automatic directed(input logic [31:0] x, input logic [31:0] y, input logic r,
                          input logic [31:0] want, input string nm);
    @(negedge clk);
    a = x; b = y; racc = r;
    @(posedge clk);
    @(posedge clk);
    #1;
    check(nm, d, want);
  endtask

  logic [31:0] bnd [0:5] = '{32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF,
                             32'h8000_0000, 32'h7FFF_FFFF, 32'h0000_000F};

  function automatic logic [31:0] pick();
    if ($urandom_range(0, 7) == 0) return bnd[$urandom_range(0, 5)];
    return $urandom;
  endfunction

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    logic [31:0] sa, sb;
    logic        sr;

    repeat (2) @(negedge clk);
    check("reset_d", d, 32'h0);
    #2 rapx = 1'b0;

    directed(32'd3,          32'hFFFF_FFFB, 1'b1, 32'hFFFF_FFF1, "acc_3_x_m5");
    directed(32'hFFFF_FFFF,  32'hFFFF_FFFF, 1'b1, 32'h0000_0001, "acc_m1_x_m1");
    directed(32'h0001_0000,  32'h0001_0000, 1'b1, 32'h0000_0000, "acc_wrap");
    directed(32'd19,         32'd33,        1'b1, 32'd627,       "acc_19_x_33");
    directed(32'd19,         32'd33,        1'b0, APX_ON ? 32'd512 : 32'd627, "apx_19_x_33");
    directed(32'h7FFF_FFFF,  32'd2,         1'b1, 32'hFFFF_FFFE, "acc_max_x_2");
    directed(32'h8000_0000,  32'h8000_0000, 1'b0, 32'h0000_0000, "apx_min_x_min");
    directed(32'd15,         32'd31,        1'b0, APX_ON ? 32'd0 : 32'd465, "apx_lsb_only");

    // Mode switch on consecutive pairs takes effect per pair.
    @(negedge clk); a = 32'd19; b = 32'd33; racc = 1'b0;
    @(negedge clk); a = 32'd19; b = 32'd33; racc = 1'b1;
    @(posedge clk); #1 check("mode_pair0", d, APX_ON ? 32'd512 : 32'd627);
    @(posedge clk); #1 check("mode_pair1", d, 32'd627);

    // Back-to-back accurate stream.
    repeat (500) begin
      @(negedge clk);
      a = pick(); b = pick(); racc = 1'b1;
    end

    // Nonzero product in flight, then asynchronous reset between edges.
    @(negedge clk); a = 32'd1234; b = 32'd5678; racc = 1'b1;
    @(negedge clk); a = 32'd7;    b = 32'd9;
    @(negedge clk);
    sa = 32'hFFFF_FF00; sb = 32'd3; sr = 1'b1;
    a = sa; b = sb; racc = sr;
    #2 rapx = 1'b1;
    #1 check("rst_async_clear", d, 32'h0);
    #1 rapx = 1'b0;
    @(posedge clk); #1 check("rst_first_capture", d, 32'h0);
    @(posedge clk); #1 check("rst_first_valid", d, 32'hFFFF_FD00);

    // Mixed-mode random stream.
    repeat (100) begin
      @(negedge clk);
      a = pick(); b = pick(); racc = 1'($urandom_range(0, 1));
    end

    @(negedge clk); a = '0; b = '0; racc = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_conf_int_mul_noff_arch_agnos_w_wrapper
